// File: rtl/bitwise_seq.sv
// -----------------------------------------------------------------------------
// bitwise_seq
//   Multi-byte sequencer for the 8-bit bitwise ALU slice. A wide operand pair
//   and op code are latched on accept, then streamed one byte per cycle
//   through the external combinational slice. Each byte's carry out is
//   chained into the next byte's carry in. The assembled wide result and the
//   final carry are held from the done pulse until the next accept.
//
// Parameters
//   NBYTES     operand width in bytes (>=2); wide width W = 8*NBYTES
//   MSB_FIRST  0: byte 0 processed first; 1: byte NBYTES-1 processed first
//
// Ports
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   start       in   1   request; accepted only in IDLE or DONE
//   op          in   3   bitwise op code, latched on accept
//   cin_init    in   1   carry into first processed byte, latched on accept
//   a_in, b_in  in   W   wide operands, latched on accept
//   busy        out  1   high while bytes are being processed
//   done        out  1   one-cycle completion pulse
//   result      out  W   assembled slice results
//   cout_final  out  1   carry out of the last processed byte
//   alu_a/alu_b out  8   current byte of the latched operands
//   alu_op      out  3   latched op code
//   alu_cin     out  1   chained carry register
//   alu_q       in   8   slice result (combinational)
//   alu_cout    in   1   slice carry out (combinational)
// -----------------------------------------------------------------------------
module bitwise_seq #(
    parameter int NBYTES    = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin_init,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout_final,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [2:0]            alu_op,
    output logic                  alu_cin,
    input  logic [7:0]            alu_q,
    input  logic                  alu_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_cout_final;

    logic [IW-1:0]   w_k;
    logic            w_last;
    logic            w_accept;

    // Physical byte lane addressed by the sequential index.
    assign w_k    = (MSB_FIRST != 0) ? (IW'(NBYTES - 1) - r_idx) : r_idx;
    assign w_last = (r_idx == IW'(NBYTES - 1));

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back: a start seen during DONE skips IDLE.
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_carry      <= 1'b0;
            r_result     <= '0;
            r_cout_final <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_op    <= op;
            r_carry <= cin_init;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_result[{w_k, 3'b000} +: 8] <= alu_q;
            r_carry                      <= alu_cout;
            if (w_last) begin
                r_cout_final <= alu_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign alu_a      = r_a[{w_k, 3'b000} +: 8];
    assign alu_b      = r_b[{w_k, 3'b000} +: 8];
    assign alu_op     = r_op;
    assign alu_cin    = r_carry;
    assign result     = r_result;
    assign cout_final = r_cout_final;

endmodule

// File: tb/tb_bitwise_seq.sv
// -----------------------------------------------------------------------------
// tb_bitwise_seq
//   Directed bench for bitwise_seq. Two instances (LSB-first and MSB-first)
//   share the same stimulus; each drives a stub slice q = a ^ b,
//   cout = ~cin, so with NBYTES=4 the final carry equals cin_init.
// -----------------------------------------------------------------------------
module tb_bitwise_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        cin_init;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        l_busy, l_done, l_cout_final, l_alu_cin, l_alu_cout;
    logic [31:0] l_result;
    logic [7:0]  l_alu_a, l_alu_b, l_alu_q;
    logic [2:0]  l_alu_op;

    logic        m_busy, m_done, m_cout_final, m_alu_cin, m_alu_cout;
    logic [31:0] m_result;
    logic [7:0]  m_alu_a, m_alu_b, m_alu_q;
    logic [2:0]  m_alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign l_alu_q    = l_alu_a ^ l_alu_b;
    assign l_alu_cout = ~l_alu_cin;
    assign m_alu_q    = m_alu_a ^ m_alu_b;
    assign m_alu_cout = ~m_alu_cin;

    bitwise_seq #(.NBYTES(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin_init(cin_init),
        .a_in(a_in), .b_in(b_in), .busy(l_busy), .done(l_done),
        .result(l_result), .cout_final(l_cout_final),
        .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_op(l_alu_op), .alu_cin(l_alu_cin),
        .alu_q(l_alu_q), .alu_cout(l_alu_cout)
    );

    bitwise_seq #(.NBYTES(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin_init(cin_init),
        .a_in(a_in), .b_in(b_in), .busy(m_busy), .done(m_done),
        .result(m_result), .cout_final(m_cout_final),
        .alu_a(m_alu_a), .alu_b(m_alu_b), .alu_op(m_alu_op), .alu_cin(m_alu_cin),
        .alu_q(m_alu_q), .alu_cout(m_alu_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete operation. With poke set, start is re-asserted with
    // unrelated operands throughout RUN; it must have no effect.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] o, input logic c,
                          input logic [31:0] exp_res, input logic exp_cout,
                          input bit poke);
        @(negedge clk);
        a_in = a; b_in = b; op = o; cin_init = c; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (poke) begin
                start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'h5555AAAA;
                op = ~o; cin_init = ~c;
            end else begin
                start = 1'b0;
            end
            chk("l_busy", 32'(l_busy), 32'd1);
            chk("m_busy", 32'(m_busy), 32'd1);
            chk("l_done_run", 32'(l_done), 32'd0);
            chk("l_alu_a", 32'(l_alu_a), 32'(a[8*i +: 8]));
            chk("l_alu_b", 32'(l_alu_b), 32'(b[8*i +: 8]));
            chk("m_alu_a", 32'(m_alu_a), 32'(a[8*(3-i) +: 8]));
            chk("m_alu_b", 32'(m_alu_b), 32'(b[8*(3-i) +: 8]));
            chk("l_alu_cin", 32'(l_alu_cin), 32'(c ^ i[0]));
            chk("m_alu_cin", 32'(m_alu_cin), 32'(c ^ i[0]));
            chk("l_alu_op", 32'(l_alu_op), 32'(o));
        end
        @(negedge clk);
        start = 1'b0;
        chk("l_done", 32'(l_done), 32'd1);
        chk("m_done", 32'(m_done), 32'd1);
        chk("l_busy_done", 32'(l_busy), 32'd0);
        chk("l_result", l_result, exp_res);
        chk("m_result", m_result, exp_res);
        chk("l_cout_final", 32'(l_cout_final), 32'(exp_cout));
        chk("m_cout_final", 32'(m_cout_final), 32'(exp_cout));
        @(negedge clk);
        chk("l_done_after", 32'(l_done), 32'd0);
        chk("l_busy_after", 32'(l_busy), 32'd0);
        chk("l_result_hold", l_result, exp_res);
        chk("l_alu_op_hold", 32'(l_alu_op), 32'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        logic [2:0]  ro;

        rst = 1'b1; start = 1'b0; op = 3'd0; cin_init = 1'b0;
        a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(l_busy), 32'd0);
        chk("rst_done", 32'(l_done), 32'd0);
        chk("rst_result", l_result, 32'd0);
        chk("rst_cout", 32'(l_cout_final), 32'd0);
        chk("rst_alu_a", 32'(l_alu_a), 32'd0);
        chk("rst_alu_b", 32'(m_alu_b), 32'd0);
        chk("rst_alu_op", 32'(l_alu_op), 32'd0);
        chk("rst_alu_cin", 32'(l_alu_cin), 32'd0);
        rst = 1'b0;

        // Basic (and MSB-first order on the second instance)
        run_op(32'h12345678, 32'h0F0F0F0F, 3'd2, 1'b0, 32'h1D3B5977, 1'b0, 1'b0);

        // Start during RUN is ignored
        run_op(32'h12345678, 32'h0F0F0F0F, 3'd6, 1'b0, 32'h1D3B5977, 1'b0, 1'b1);

        // Back-to-back: start held across DONE
        @(negedge clk);
        a_in = 32'h12345678; b_in = 32'h0F0F0F0F; op = 3'd1; cin_init = 1'b0;
        start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("b2b_done", 32'(l_done), (j % 5 == 4) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(l_busy), (j % 5 == 4) ? 32'd0 : 32'd1);
            if (j == 4) begin
                chk("b2b_res1", l_result, 32'h1D3B5977);
                chk("b2b_cout1", 32'(l_cout_final), 32'd0);
                a_in = 32'hFFFFFFFF; cin_init = 1'b1;
            end
            if (j == 9) begin
                chk("b2b_res2", l_result, 32'hF0F0F0F0);
                chk("b2b_res2_m", m_result, 32'hF0F0F0F0);
                chk("b2b_cout2", 32'(l_cout_final), 32'd1);
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle_done", 32'(l_done), 32'd0);
        chk("b2b_idle_busy", 32'(l_busy), 32'd0);

        // Asynchronous reset in the middle of RUN (idx=2)
        @(negedge clk);
        a_in = 32'h11223344; b_in = 32'h55667788; op = 3'd3; cin_init = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(l_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(l_busy), 32'd0);
        chk("arst_done", 32'(l_done), 32'd0);
        chk("arst_result", l_result, 32'd0);
        chk("arst_cout", 32'(l_cout_final), 32'd0);
        chk("arst_alu_a", 32'(l_alu_a), 32'd0);
        chk("arst_alu_b_m", 32'(m_alu_b), 32'd0);
        chk("arst_alu_op", 32'(l_alu_op), 32'd0);
        chk("arst_alu_cin", 32'(l_alu_cin), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(l_done), 32'd0);
            chk("post_rst_busy", 32'(l_busy), 32'd0);
        end
        run_op(32'hA5A5A5A5, 32'hFFFF0000, 3'd5, 1'b1, 32'h5A5AA5A5, 1'b1, 1'b0);

        // Random operands through the stub slice
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ro = 3'($urandom_range(0, 7));
            run_op(ra, rb, ro, rc, ra ^ rb, rc, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
